uart_rx_deframer: RTL and testbench

Serial receive front end for the 7-bit UART path. It samples an asynchronous idle-high serial line and strips the start, parity and stop bits. It delivers each 7-bit character on a parallel port with a one-cycle `valid` strobe plus parity/framing status. It sits directly downstream of the serial line and feeds the 7-bit parallel interface (`data`/`save`) of the `uart` block.

---
 rtl/uart_rx_deframer.sv | 115 +++++++++++
 tb/tb_uart_rx_deframer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 7-bit UART receive deframer (start, 7 data LSB first, parity, stop)
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [6:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s, rx_q;
  logic [TW-1:0]   timer, timer_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [6:0]      shreg, shreg_nxt;
  logic            par_bit, par_nxt;
  logic [6:0]      data_nxt;
  logic            valid_nxt, perr_nxt, ferr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_q       <= 1'b1;
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_q       <= rx_s;
      state      <= state_nxt;
      timer      <= timer_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      par_bit    <= par_nxt;
      data_out   <= data_nxt;
      valid      <= valid_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TW'(1);
    idx_nxt   = idx;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    perr_nxt  = parity_err;
    ferr_nxt  = frame_err;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        // Edge-triggered so a line stuck low after a framing error cannot retrigger.
        if (rx_q && !rx_s) state_nxt = START;
      end
      START: begin
        if (timer == HALF_LAST) begin
          timer_nxt = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          shreg_nxt = {rx_s, shreg[6:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd6) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          par_nxt   = rx_s;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          data_nxt  = shreg;
          perr_nxt  = ((^shreg) ^ par_bit) != PARITY_ODD;
          ferr_nxt  = !rx_s;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed bench for uart_rx_deframer
module tb_uart_rx_deframer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [6:0] data_out, d_o;
  logic       valid, parity_err, frame_err, busy;
  logic       v_o, pe_o, fe_o, b_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int n0 = 0;
  int vcnt = 0;
  int vcyc = 0;
  int vprev = 0;
  int brise = 0;
  int bfall = 0;
  logic busy_d = 1'b0;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(d_o), .valid(v_o),
    .parity_err(pe_o), .frame_err(fe_o), .busy(b_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcnt  <= vcnt + 1;
      vprev <= vcyc;
      vcyc  <= cyc;
    end
    if (busy && !busy_d) brise <= cyc;
    if (!busy && busy_d) bfall <= cyc;
    busy_d <= busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stp);
    logic [9:0] bits;
    bits = {stp, par, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      wait_cycles(CPB);
    end
  endtask

  initial begin
    wait_cycles(3);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_cycles(5);

    // good frame 0x66, even parity
    n0 = vcnt;
    send_frame(7'h66, 1'b0, 1'b1);
    wait_cycles(CPB);
    check("good_count", 32'(vcnt - n0), 32'd1);
    check("good_latency", 32'(vcyc - t0), 32'd155);
    check("busy_rise", 32'(brise - t0), 32'd3);
    check("busy_fall", 32'(bfall), 32'(vcyc));
    check("good_data", 32'(data_out), 32'h66);
    check("good_perr", 32'(parity_err), 32'h0);
    check("good_ferr", 32'(frame_err), 32'h0);
    check("good_busy", 32'(busy), 32'h0);
    check("odd_perr_on_even", 32'(pe_o), 32'h1);

    // parity error
    send_frame(7'h66, 1'b1, 1'b1);
    wait_cycles(CPB);
    check("perr_data", 32'(data_out), 32'h66);
    check("perr_perr", 32'(parity_err), 32'h1);
    check("perr_ferr", 32'(frame_err), 32'h0);
    check("odd_perr_ok", 32'(pe_o), 32'h0);

    // framing error, line held low
    n0 = vcnt;
    send_frame(7'h2A, 1'b1, 1'b0);
    rx = 1'b0;
    wait_cycles(40 * CPB);
    check("ferr_data", 32'(data_out), 32'h2A);
    check("ferr_ferr", 32'(frame_err), 32'h1);
    check("ferr_perr", 32'(parity_err), 32'h0);
    check("ferr_count", 32'(vcnt - n0), 32'd1);
    rx = 1'b1;
    wait_cycles(40);
    check("ferr_no_more", 32'(vcnt - n0), 32'd1);
    check("ferr_busy", 32'(busy), 32'h0);

    // false start
    n0 = vcnt;
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(40);
    check("fs_count", 32'(vcnt - n0), 32'd0);
    check("fs_data", 32'(data_out), 32'h2A);
    check("fs_ferr", 32'(frame_err), 32'h1);
    check("fs_busy", 32'(busy), 32'h0);

    // back-to-back frames
    n0 = vcnt;
    send_frame(7'h00, 1'b0, 1'b1);
    check("b2b_data0", 32'(data_out), 32'h00);
    send_frame(7'h7F, 1'b1, 1'b1);
    wait_cycles(CPB);
    check("b2b_data1", 32'(data_out), 32'h7F);
    check("b2b_perr", 32'(parity_err), 32'h0);
    check("b2b_ferr", 32'(frame_err), 32'h0);
    check("b2b_count", 32'(vcnt - n0), 32'd2);
    check("b2b_gap", 32'(vcyc - vprev), 32'd160);

    // reset during data bit 3 of 0x55
    n0 = vcnt;
    rx = 1'b0;
    wait_cycles(CPB);
    rx = 1'b1; wait_cycles(CPB);
    rx = 1'b0; wait_cycles(CPB);
    rx = 1'b1; wait_cycles(CPB);
    rx = 1'b0; wait_cycles(5);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_perr", 32'(parity_err), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(40);
    check("post_rst_count", 32'(vcnt - n0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'h0);
    send_frame(7'h55, 1'b0, 1'b1);
    wait_cycles(CPB);
    check("after_rst_data", 32'(data_out), 32'h55);
    check("after_rst_perr", 32'(parity_err), 32'h0);
    check("after_rst_ferr", 32'(frame_err), 32'h0);
    check("after_rst_count", 32'(vcnt - n0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
